// File: rtl/inst_mem_banked_if.sv
`default_nettype none
// ============================================================================
// inst_mem_banked_if : loader and fetch bus of the banked instruction memory
// Revision: 1.0
// ============================================================================
interface inst_mem_banked_if #(
  parameter int IW    = 8,
  parameter int DW    = 9,
  parameter int NPROG = 3
);
  localparam int PW = (NPROG > 1) ? $clog2(NPROG) : 1;

  logic          load_start;
  logic [PW-1:0] load_bank;
  logic          load_valid;
  logic [DW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          load_done;
  logic          load_err;
  logic [IW:0]   load_len;
  logic          busy;
  logic          fetch_en;
  logic [PW-1:0] prog_sel;
  logic [IW-1:0] inst_address;
  logic [DW-1:0] inst_out;
  logic          inst_valid;

  modport master (
    output load_start, load_bank, load_valid, load_data, load_last,
    output fetch_en, prog_sel, inst_address,
    input  load_ready, load_done, load_err, load_len, busy,
    input  inst_out, inst_valid
  );

  modport slave (
    input  load_start, load_bank, load_valid, load_data, load_last,
    input  fetch_en, prog_sel, inst_address,
    output load_ready, load_done, load_err, load_len, busy,
    output inst_out, inst_valid
  );
endinterface
`default_nettype wire

// File: rtl/inst_mem_banked.sv
`default_nettype none
// ============================================================================
// inst_mem_banked : NPROG run-time loadable instruction banks, registered fetch
// Revision: 1.0
// ============================================================================
module inst_mem_banked #(
  parameter int IW    = 8,
  parameter int DW    = 9,
  parameter int NPROG = 3
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  inst_mem_banked_if.slave  bus
);
  localparam int PW    = (NPROG > 1) ? $clog2(NPROG) : 1;
  localparam int DEPTH = 2 ** IW;

  localparam logic [PW:0]   c_nprog     = (PW + 1)'(NPROG);
  localparam logic [IW-1:0] c_last_addr = '1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_bank;
  logic [IW-1:0] r_wr_ptr;
  logic [IW:0]   r_load_len;
  logic          r_load_done;
  logic          r_load_err;
  logic [DW-1:0] r_inst_out;
  logic          r_inst_valid;

  logic          w_start_ok;
  logic          w_start_err;
  logic          w_wr_en;
  logic          w_load_end;
  logic          w_fetch;
  logic [DW-1:0] w_rd_data;

  // Contents survive reset so a reset mid-load keeps the words already written.
  logic [DW-1:0] r_mem [NPROG][DEPTH] = '{default: '0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_ok  = 1'b0;
    w_start_err = 1'b0;
    w_wr_en     = 1'b0;
    w_load_end  = 1'b0;
    w_fetch     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // A load request always takes priority over a same-cycle fetch.
        if (bus.load_start) begin
          if ({1'b0, bus.load_bank} < c_nprog) begin
            w_start_ok  = 1'b1;
            w_state_nxt = ST_LOAD;
          end else begin
            w_start_err = 1'b1;
          end
        end else begin
          w_fetch = bus.fetch_en;
        end
      end
      ST_LOAD: begin
        if (bus.load_valid) begin
          w_wr_en = 1'b1;
          if (bus.load_last || (r_wr_ptr == c_last_addr)) begin
            w_load_end  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_bank][r_wr_ptr] <= bus.load_data;
    end
  end

  assign w_rd_data = ({1'b0, bus.prog_sel} < c_nprog) ?
                     r_mem[bus.prog_sel][bus.inst_address] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bank       <= '0;
      r_wr_ptr     <= '0;
      r_load_len   <= '0;
      r_load_done  <= 1'b0;
      r_load_err   <= 1'b0;
      r_inst_out   <= '0;
      r_inst_valid <= 1'b0;
    end else begin
      r_load_done  <= w_load_end;
      r_load_err   <= w_start_err;
      r_inst_valid <= w_fetch;
      if (w_start_ok) begin
        r_bank   <= bus.load_bank;
        r_wr_ptr <= '0;
      end else if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      // The pointer doubles as the word counter: the final word index plus one.
      if (w_load_end) begin
        r_load_len <= {1'b0, r_wr_ptr} + 1'b1;
      end
      if (w_fetch) begin
        r_inst_out <= w_rd_data;
      end
    end
  end

  assign bus.load_ready = (r_state == ST_LOAD);
  assign bus.busy       = (r_state == ST_LOAD);
  assign bus.load_done  = r_load_done;
  assign bus.load_err   = r_load_err;
  assign bus.load_len   = r_load_len;
  assign bus.inst_out   = r_inst_out;
  assign bus.inst_valid = r_inst_valid;
endmodule
`default_nettype wire

// File: tb/tb_inst_mem_banked.sv
`default_nettype none
// ============================================================================
// tb_inst_mem_banked : directed bench for inst_mem_banked (IW=4, DW=9, NPROG=3)
// Revision: 1.0
// ============================================================================
module tb_inst_mem_banked;
  localparam int IW    = 4;
  localparam int DW    = 9;
  localparam int NPROG = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  inst_mem_banked_if #(.IW(IW), .DW(DW), .NPROG(NPROG)) bus ();

  inst_mem_banked #(.IW(IW), .DW(DW), .NPROG(NPROG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic idle_inputs();
    bus.load_start   = 1'b0;
    bus.load_bank    = '0;
    bus.load_valid   = 1'b0;
    bus.load_data    = '0;
    bus.load_last    = 1'b0;
    bus.fetch_en     = 1'b0;
    bus.prog_sel     = '0;
    bus.inst_address = '0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.inst_out !== 9'h000) begin errors++; $display("FAIL rst_inst_out got %h exp 000", bus.inst_out); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_inst_valid got %b exp 0", bus.inst_valid); end
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL rst_load_ready got %b exp 0", bus.load_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    checks++; if (bus.load_done !== 1'b0 || bus.load_err !== 1'b0) begin errors++; $display("FAIL rst_pulses got done=%b err=%b exp 0 0", bus.load_done, bus.load_err); end
    checks++; if (bus.load_len !== 5'd0) begin errors++; $display("FAIL rst_load_len got %0d exp 0", bus.load_len); end
    @(negedge clk) rst_n = 1'b1;
    // Start a load on bank 2 and pull reset in the middle of a cycle.
    bus.load_start = 1'b1; bus.load_bank = 2'd2;
    @(negedge clk);
    bus.load_start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got %b exp 1", bus.busy); end
    bus.load_valid = 1'b1; bus.load_data = 9'h1AA;
    @(negedge clk) bus.load_data = 9'h1AB;
    @(posedge clk) #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.load_ready !== 1'b0) begin errors++; $display("FAIL rst_async_busy got busy=%b ready=%b exp 0 0", bus.busy, bus.load_ready); end
    checks++; if (bus.load_done !== 1'b0 || bus.load_len !== 5'd0) begin errors++; $display("FAIL rst_async_done got done=%b len=%0d exp 0 0", bus.load_done, bus.load_len); end
    checks++; if (bus.inst_valid !== 1'b0 || bus.inst_out !== 9'h000) begin errors++; $display("FAIL rst_async_fetch got valid=%b out=%h exp 0 000", bus.inst_valid, bus.inst_out); end
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    bus.fetch_en = 1'b1; bus.prog_sel = 2'd0; bus.inst_address = 4'd3;
    @(negedge clk);
    checks++; if (bus.inst_out !== 9'h000 || bus.inst_valid !== 1'b1) begin errors++; $display("FAIL rst_fetch got out=%h valid=%b exp 000 1", bus.inst_out, bus.inst_valid); end
    bus.fetch_en = 1'b0;
    @(negedge clk);
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_fetch_idle got valid=%b exp 0", bus.inst_valid); end
  endtask

  task automatic test_load_readback();
    logic [DW-1:0] exp_v;
    bus.load_start = 1'b1; bus.load_bank = 2'd1;
    @(negedge clk);
    bus.load_start = 1'b0;
    checks++; if (bus.busy !== 1'b1 || bus.load_ready !== 1'b1) begin errors++; $display("FAIL ld_enter got busy=%b ready=%b exp 1 1", bus.busy, bus.load_ready); end
    for (int i = 0; i < 5; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 9'(32'h101 + i);
      bus.load_last  = (i == 4);
      @(negedge clk);
    end
    bus.load_valid = 1'b0; bus.load_last = 1'b0;
    checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL ld_done got %b exp 1", bus.load_done); end
    checks++; if (bus.load_len !== 5'd5) begin errors++; $display("FAIL ld_len got %0d exp 5", bus.load_len); end
    checks++; if (bus.busy !== 1'b0 || bus.load_ready !== 1'b0) begin errors++; $display("FAIL ld_exit got busy=%b ready=%b exp 0 0", bus.busy, bus.load_ready); end
    bus.fetch_en = 1'b1; bus.prog_sel = 2'd1;
    for (int i = 0; i < 5; i++) begin
      bus.inst_address = 4'(i);
      @(negedge clk);
      exp_v = 9'(32'h101 + i);
      checks++; if (bus.inst_out !== exp_v || bus.inst_valid !== 1'b1) begin errors++; $display("FAIL rd_bank1_%0d got out=%h valid=%b exp %h 1", i, bus.inst_out, bus.inst_valid, exp_v); end
      if (i == 0) begin
        checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL ld_done_pulse got %b exp 0", bus.load_done); end
      end
    end
    bus.prog_sel = 2'd0;
    for (int i = 0; i < 3; i++) begin
      bus.inst_address = 4'(i);
      @(negedge clk);
      checks++; if (bus.inst_out !== 9'h000) begin errors++; $display("FAIL rd_bank0_%0d got %h exp 000", i, bus.inst_out); end
    end
    bus.fetch_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_depth();
    int done_cnt = 0;
    bus.load_start = 1'b1; bus.load_bank = 2'd2;
    @(negedge clk);
    bus.load_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 9'(32'h0A0 + i);
      @(negedge clk);
      if (bus.load_done) done_cnt++;
      if (i < 15) begin
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL dep_ready_%0d got %b exp 1", i, bus.load_ready); end
      end else if (i == 15) begin
        checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL dep_done got %b exp 1", bus.load_done); end
        checks++; if (bus.load_len !== 5'd16) begin errors++; $display("FAIL dep_len got %0d exp 16", bus.load_len); end
      end
      if (i >= 15) begin
        checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL dep_stop_%0d got ready=%b exp 0", i, bus.load_ready); end
      end
    end
    bus.load_valid = 1'b0;
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL dep_done_count got %0d exp 1", done_cnt); end
    bus.fetch_en = 1'b1; bus.prog_sel = 2'd2; bus.inst_address = 4'd15;
    @(negedge clk);
    checks++; if (bus.inst_out !== 9'h0AF) begin errors++; $display("FAIL dep_rd15 got %h exp 0af", bus.inst_out); end
    bus.inst_address = 4'd0;
    @(negedge clk);
    checks++; if (bus.inst_out !== 9'h0A0) begin errors++; $display("FAIL dep_rd0 got %h exp 0a0", bus.inst_out); end
    bus.fetch_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_illegal_bank();
    bus.fetch_en = 1'b1; bus.prog_sel = 2'd1; bus.inst_address = 4'd4;
    @(negedge clk);
    checks++; if (bus.inst_out !== 9'h105) begin errors++; $display("FAIL ill_pre got %h exp 105", bus.inst_out); end
    bus.fetch_en = 1'b0;
    bus.load_start = 1'b1; bus.load_bank = 2'd3;
    @(negedge clk);
    bus.load_start = 1'b0;
    checks++; if (bus.load_err !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL ill_err got err=%b busy=%b exp 1 0", bus.load_err, bus.busy); end
    @(negedge clk);
    checks++; if (bus.load_err !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL ill_err_pulse got err=%b busy=%b exp 0 0", bus.load_err, bus.busy); end
    bus.fetch_en = 1'b1; bus.prog_sel = 2'd3; bus.inst_address = 4'd4;
    @(negedge clk);
    checks++; if (bus.inst_out !== 9'h000 || bus.inst_valid !== 1'b1) begin errors++; $display("FAIL ill_fetch got out=%h valid=%b exp 000 1", bus.inst_out, bus.inst_valid); end
    bus.fetch_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_collision();
    bus.fetch_en = 1'b1; bus.prog_sel = 2'd1; bus.inst_address = 4'd2;
    @(negedge clk);
    checks++; if (bus.inst_out !== 9'h103) begin errors++; $display("FAIL col_pre got %h exp 103", bus.inst_out); end
    bus.load_start = 1'b1; bus.load_bank = 2'd0;
    bus.prog_sel = 2'd0; bus.inst_address = 4'd0;
    @(negedge clk);
    bus.load_start = 1'b0;
    checks++; if (bus.inst_valid !== 1'b0 || bus.inst_out !== 9'h103 || bus.busy !== 1'b1) begin errors++; $display("FAIL col_same got valid=%b out=%h busy=%b exp 0 103 1", bus.inst_valid, bus.inst_out, bus.busy); end
    @(negedge clk);
    checks++; if (bus.inst_valid !== 1'b0 || bus.inst_out !== 9'h103) begin errors++; $display("FAIL col_inload got valid=%b out=%h exp 0 103", bus.inst_valid, bus.inst_out); end
    bus.load_valid = 1'b1; bus.load_data = 9'h1FF; bus.load_last = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0; bus.load_last = 1'b0;
    checks++; if (bus.load_done !== 1'b1 || bus.load_len !== 5'd1 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL col_done got done=%b len=%0d valid=%b exp 1 1 0", bus.load_done, bus.load_len, bus.inst_valid); end
    @(negedge clk);
    checks++; if (bus.inst_out !== 9'h1FF || bus.inst_valid !== 1'b1) begin errors++; $display("FAIL col_rd_after_load got out=%h valid=%b exp 1ff 1", bus.inst_out, bus.inst_valid); end
    bus.fetch_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_midload();
    logic [DW-1:0] exp_tab [8];
    exp_tab = '{9'h0C0, 9'h0C1, 9'h0C2, 9'h104, 9'h105, 9'h000, 9'h000, 9'h000};
    bus.load_start = 1'b1; bus.load_bank = 2'd1;
    @(negedge clk);
    bus.load_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.load_valid = 1'b1;
      bus.load_data  = 9'(32'h0C0 + i);
      @(negedge clk);
    end
    bus.load_data = 9'h0C3;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rml_busy got %b exp 1", bus.busy); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0 || bus.load_len !== 5'd0 || bus.load_done !== 1'b0) begin errors++; $display("FAIL rml_abort got busy=%b len=%0d done=%b exp 0 0 0", bus.busy, bus.load_len, bus.load_done); end
    bus.load_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL rml_no_done got %b exp 0", bus.load_done); end
    bus.fetch_en = 1'b1; bus.prog_sel = 2'd1;
    for (int i = 0; i < 8; i++) begin
      bus.inst_address = 4'(i);
      @(negedge clk);
      checks++; if (bus.inst_out !== exp_tab[i]) begin errors++; $display("FAIL rml_rd_%0d got %h exp %h", i, bus.inst_out, exp_tab[i]); end
    end
    bus.fetch_en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_load_readback();
    test_depth();
    test_illegal_bank();
    test_collision();
    test_reset_midload();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/inst_mem_banked.md
# inst_mem_banked

Loadable, multi-program instruction memory for the single-cycle/multicycle CPU fetch stage. Holds NPROG independent program banks of 2**IW words × DW bits each. A handshaked loader writes any bank at run time, and a registered fetch port reads the bank chosen by ProgSel. This lets one build run every test program without re-elaborating, replacing the elaboration-time program select.

## Interface
- IW, 8: address width; each bank depth is 2**IW.
- DW, 9: instruction width.
- NPROG, 3: number of program banks (≥1); PW = max(1, $clog2(NPROG)) is derived, not a parameter.
- Clk  in  1  clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- LoadStart  in  1  request to begin loading bank LoadBank from address 0.
- LoadBank  in  PW  target bank; sampled only when LoadStart is accepted.
- LoadValid  in  1  LoadData is valid.
- LoadData  in  DW  instruction word to write.
- LoadLast  in  1  qualifies the final word of the load.
- LoadReady  out  1  loader can accept a word (high only in LOAD).
- LoadDone  out  1  one-cycle pulse when a load completes.
- LoadErr  out  1  one-cycle pulse when LoadStart is rejected.
- LoadLen  out  IW+1  number of words written by the most recent completed load.
- Busy  out  1  high while in LOAD.
- FetchEn  in  1  fetch request.
- ProgSel  in  PW  bank to fetch from.
- InstAddress  in  IW  fetch address.
- InstOut  out  DW  fetched instruction (registered).
- InstValid  out  1  InstOut was updated by a fetch accepted last cycle.

## Operation
- Storage: NPROG × 2**IW × DW array, all zeros at elaboration. Reset does not clear it.
- FSM has two states:
  - IDLE: fetches are serviced.
    - LoadStart with LoadBank < NPROG → LOAD. Latch the bank, clear the write pointer WrPtr and the word counter.
    - LoadStart with LoadBank ≥ NPROG → stay in IDLE and pulse LoadErr.
  - LOAD: LoadReady=1 and Busy=1.
    - A word is accepted when LoadValid && LoadReady. It is written to bank[latched][WrPtr], then WrPtr and the counter increment.
    - Accepting a word with LoadLast=1, or the word at WrPtr = 2**IW−1, ends the load. The FSM returns to IDLE, pulses LoadDone and sets LoadLen = words written (1..2**IW).
    - LoadStart is ignored in LOAD.
- Fetch (IDLE only): FetchEn=1 registers InstOut ← bank[ProgSel][InstAddress] and sets InstValid=1 next cycle.
  - ProgSel ≥ NPROG returns all zeros, still with InstValid=1.
  - FetchEn=0, or any cycle in LOAD, gives InstValid=0 and InstOut holds its value.
- Simultaneous LoadStart and FetchEn in IDLE: the load wins and the fetch is dropped (InstValid=0 next cycle).
- Words in the bank beyond LoadLen keep their previous contents.

## Timing
- Reset values: state IDLE, InstOut=0, InstValid=0, LoadReady=0, Busy=0, LoadDone=0, LoadErr=0, LoadLen=0, WrPtr=0.
- Reset asserted mid-load aborts immediately. Words already written stay in memory, LoadDone does not pulse, and LoadLen returns to 0.
- LoadStart accepted at edge k: LoadReady=1 and Busy=1 from cycle k+1.
- A final word accepted at edge m: LoadDone=1, LoadReady=0 and Busy=0 during cycle m+1, and LoadLen is valid from cycle m+1. A fetch is accepted at edge m+1 at the earliest.
- Fetch latency is 1 cycle: request at edge n, data and InstValid visible after edge n. Read-after-load returns the new data with no extra delay.
- Throughput: 1 load word per cycle; 1 fetch per cycle.
- LoadValid held high with no LoadLast loads exactly 2**IW words, then stops: LoadReady drops and later words are not accepted.

## Test plan
- Reset: with IW=4, drive Reset_n=0 mid-stream → every output goes to its reset value without waiting for a clock edge. After release, FetchEn to bank 0 address 3 → InstOut=0, InstValid=1.
- Load and read back: load bank 1 with 5 words 9'h101..9'h105, LoadLast on the 5th → LoadDone one cycle, LoadLen=5. Fetch ProgSel=1 at addresses 0..4 → 9'h101..9'h105 on consecutive cycles; bank 0 is still zeros.
- Depth exhaustion: with IW=4, stream 20 words with no LoadLast → exactly 16 are accepted, LoadDone fires after the 16th, LoadLen=16, LoadReady=0.
- Illegal bank: NPROG=3, LoadStart with LoadBank=3 → LoadErr for 1 cycle, Busy stays 0. A fetch with ProgSel=3 → InstOut=0, InstValid=1.
- Collision: LoadStart and FetchEn in the same cycle → InstValid=0 next cycle. FetchEn during LOAD → InstValid stays 0 and InstOut holds its prior value.
- Reset mid-load: reset after 3 of 8 words → LoadLen=0, no LoadDone. Fetches show the 3 new words at addresses 0..2 and old contents at addresses 3..7.
